// File: rtl/serial_pkg.sv
// Shared serial-link constants and receiver state encoding.
// Used by serial_rx and reusable by the matching transmitter.
package serial_pkg;

   localparam int TICKS_PER_BIT = 16;
   localparam int MID_SAMPLE    = 8;
   localparam int DATA_BITS     = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HUNT      = 3'd1,
      START_BIT = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4,
      DONE      = 3'd5
   } rx_state_t;

endpackage

// File: rtl/serial_baud_tick.sv
// Baud tick generator: one tick every CLOCK+1 cycles, plus a 4-bit
// sub-tick counter that advances on each tick (16 ticks per bit).
module serial_baud_tick #(
   parameter int CLOCK = 26
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   output logic       o_tick,
   output logic [3:0] o_subtick
);

   localparam int CW = (CLOCK > 0) ? $clog2(CLOCK + 1) : 1;

   logic [CW-1:0] r_slck;
   logic [3:0]    r_sub;

   assign o_tick    = i_en && (r_slck == CW'(CLOCK));
   assign o_subtick = r_sub;

   // Divider and sub-tick counter; clear re-phases both to the start edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_slck <= '0;
         r_sub  <= '0;
      end else if (i_en) begin
         if (o_tick) begin
            r_slck <= '0;
            r_sub  <= r_sub + 4'd1;
         end else begin
            r_slck <= r_slck + CW'(1);
         end
      end
   end

endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 LSB-first receiver capturing BUFFLEN characters into BUFFER,
// with a START/END level handshake. Optional build macro SERIAL_RX_MAJORITY_EN
// selects 2-of-3 voting over sub-ticks 7,8,9 instead of one sample at 8.
module serial_rx
   import serial_pkg::*;
#(
   parameter int BUFFLEN = 5,
   parameter int CLOCK   = 26
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic                 RXD,
   output logic                 END,
   output logic                 FRAME_ERR,
   output logic [0:8*BUFFLEN-1] BUFFER
);

   localparam int CCW = $clog2(BUFFLEN + 1);
   localparam int IXW = $clog2(8 * BUFFLEN);
`ifdef SERIAL_RX_MAJORITY_EN
   localparam logic [3:0] DEC_SUB = 4'(MID_SAMPLE + 1);
`else
   localparam logic [3:0] DEC_SUB = 4'(MID_SAMPLE);
`endif

   rx_state_t            r_state, w_next;
   logic                 r_rx_s1, r_rx_s2, r_rx_prev;
   logic [CCW-1:0]       r_charcount;
   logic [2:0]           r_bitcnt;
   logic                 r_end, r_ferr;
   logic [0:8*BUFFLEN-1] r_buf;

   logic                 w_tick, w_clr, w_en, w_fall, w_dec, w_bit, w_last;
   logic [3:0]           w_sub;
   logic [IXW-1:0]       w_idx;

   serial_baud_tick #(.CLOCK(CLOCK)) u_tick (
      .i_clk     (CLK),
      .i_rst_n   (RESET),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .o_tick    (w_tick),
      .o_subtick (w_sub)
   );

   // Two-flop synchroniser plus one history flop for start-edge detection.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= RXD;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   assign w_fall = r_rx_prev && !r_rx_s2;
   assign w_dec  = w_tick && (w_sub == DEC_SUB);
   assign w_last = (r_charcount == CCW'(BUFFLEN - 1));
   assign w_idx  = IXW'(8 * int'(r_charcount) + 7 - int'(r_bitcnt));

`ifdef SERIAL_RX_MAJORITY_EN
   logic r_s7, r_s8;

   // Hold the sub-tick 7 and 8 samples for the vote taken at sub-tick 9.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_s7 <= 1'b1;
         r_s8 <= 1'b1;
      end else if (w_tick) begin
         if (w_sub == 4'(MID_SAMPLE - 1)) r_s7 <= r_rx_s2;
         if (w_sub == 4'(MID_SAMPLE))     r_s8 <= r_rx_s2;
      end
   end

   assign w_bit = (r_s7 & r_s8) | (r_s7 & r_rx_s2) | (r_s8 & r_rx_s2);
`else
   assign w_bit = r_rx_s2;
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (!RESET) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; START low anywhere mid-transfer aborts to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (START && !r_end) w_next = HUNT;
         HUNT:      if (!START) w_next = IDLE;
                    else if (w_fall) w_next = START_BIT;
         START_BIT: if (!START) w_next = IDLE;
                    else if (w_dec) w_next = w_bit ? HUNT : DATA;
         DATA:      if (!START) w_next = IDLE;
                    else if (w_dec && r_bitcnt == 3'(DATA_BITS - 1)) w_next = STOP;
         STOP:      if (!START) w_next = IDLE;
                    else if (w_dec) w_next = w_last ? DONE : HUNT;
         DONE:      if (!START) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Timer control: run while receiving, re-phase on arm and on each start edge.
   always_comb begin
      w_en  = (r_state != IDLE) && (r_state != DONE);
      w_clr = (r_state == IDLE) || ((r_state == HUNT) && w_fall);
   end

   // Character/bit counters, buffer writes, error flag and END handshake.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_charcount <= '0;
         r_bitcnt    <= '0;
         r_end       <= 1'b0;
         r_ferr      <= 1'b0;
         r_buf       <= '0;
      end else begin
         case (r_state)
            IDLE: if (START && !r_end) begin
               r_charcount <= '0;
               r_ferr      <= 1'b0;
            end
            START_BIT: r_bitcnt <= '0;
            DATA: if (START && w_dec) begin
               r_buf[w_idx] <= w_bit;
               r_bitcnt     <= r_bitcnt + 3'd1;
            end
            STOP: if (START && w_dec) begin
               if (!w_bit) r_ferr <= 1'b1;
               r_charcount <= r_charcount + CCW'(1);
               if (w_last) r_end <= 1'b1;
            end
            DONE: if (!START) r_end <= 1'b0;
            default: ;
         endcase
      end
   end

   assign END       = r_end;
   assign FRAME_ERR = r_ferr;
   assign BUFFER    = r_buf;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx (BUFFLEN=5, CLOCK=1 -> 32 clocks per bit).
// Completed transfers are checked by a scoreboard monitor on END rising.
module tb_serial_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rxd = 1'b1;
   logic        done_o;
   logic        ferr;
   logic [0:39] buffer;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [39:0] data;
      logic        fe;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   serial_rx #(.BUFFLEN(5), .CLOCK(1)) dut (
      .CLK       (clk),
      .RESET     (rst_n),
      .START     (start),
      .RXD       (rxd),
      .END       (done_o),
      .FRAME_ERR (ferr),
      .BUFFER    (buffer)
   );

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every END rising edge must match the oldest expected transfer.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done_o === 1'b1 && !prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected END: got END=1 expected no transfer");
            end else begin
               e = sb.pop_front();
               chk("sb BUFFER", buffer, e.data);
               chk("sb FRAME_ERR", 40'(ferr), 40'(e.fe));
            end
         end
         prev = (done_o === 1'b1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   // Reference TX: start, 8 data LSB first, stop; optional 1-cycle glitch
   // 18 clocks into data bit gbit (where the single sample would land).
   task automatic send_char(input logic [7:0] c, input bit stop_ok, input int gbit);
      drive(1'b0, 32);
      for (int i = 0; i < 8; i++) begin
         if (i == gbit) begin
            drive(c[i], 18);
            drive(~c[i], 1);
            drive(c[i], 13);
         end else begin
            drive(c[i], 32);
         end
      end
      drive(stop_ok, 32);
      if (!stop_ok) drive(1'b1, 32);
   endtask

   task automatic send_str(input string s, input int bad, input int gbit);
      for (int i = 0; i < s.len(); i++)
         send_char(s[i], i != bad, (i == 0) ? gbit : -1);
   endtask

   task automatic wait_end(input string nm);
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 40'(done_o), 40'd1);
      repeat (2) @(negedge clk);
      chk({nm, " sb drained"}, 40'(sb.size()), 40'd0);
   endtask

   task automatic arm();
      @(negedge clk);
      start = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic disarm();
      start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset END", 40'(done_o), 40'd0);
      chk("reset FRAME_ERR", 40'(ferr), 40'd0);
      chk("reset BUFFER", buffer, 40'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: basic transfer
      arm();
      sb.push_back('{40'h4142434445, 1'b0});
      send_str("ABCDE", -1, -1);
      wait_end("t1 END");

      // 2: END held while START high, clears one cycle after START drops
      start = 1'b0;
      chk("t2 END held", 40'(done_o), 40'd1);
      @(posedge clk);
      #1;
      chk("t2 END clears", 40'(done_o), 40'd0);
      arm();
      sb.push_back('{40'h7A7A7A7A7A, 1'b0});
      send_str("zzzzz", -1, -1);
      wait_end("t2 END");

      // 3: short low glitch on idle line is rejected
      disarm();
      arm();
      drive(1'b0, 8);
      drive(1'b1, 64);
      sb.push_back('{40'h4142434445, 1'b0});
      send_str("ABCDE", -1, -1);
      wait_end("t3 END");

      // 4: bad stop bit on char 2
      disarm();
      arm();
      sb.push_back('{40'h464748494A, 1'b1});
      send_str("FGHIJ", 2, -1);
      wait_end("t4 END");

      // 5: abort after two chars keeps partial buffer, no END
      disarm();
      arm();
      chk("t5 FRAME_ERR cleared on arm", 40'(ferr), 40'd0);
      send_str("PQ", -1, -1);
      drive(1'b1, 64);
      start = 1'b0;
      repeat (100) @(negedge clk);
      chk("t5 END stays low", 40'(done_o), 40'd0);
      chk("t5 partial BUFFER", buffer, 40'h505148494A);

      // 6: reset pulse in the middle of char 3
      arm();
      send_str("AB", -1, -1);
      drive(1'b0, 32);
      drive(1'b1, 32);
      drive(1'b0, 16);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rxd = 1'b1;
      chk("t6 END", 40'(done_o), 40'd0);
      chk("t6 FRAME_ERR", 40'(ferr), 40'd0);
      chk("t6 BUFFER", buffer, 40'd0);
      repeat (64) @(negedge clk);
      chk("t6 no END after reset", 40'(done_o), 40'd0);

`ifdef SERIAL_RX_MAJORITY_EN
      // 6b: single-cycle glitch at the mid sample is outvoted
      sb.push_back('{40'h4142434445, 1'b0});
      send_str("ABCDE", -1, 2);
      wait_end("t6 majority END");
`endif

      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("final sb empty", 40'(sb.size()), 40'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
